// File: rtl/psum_accum_pkg.sv
// Shared types and defaults for the partial-sum accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psum_accum_pkg;

   localparam int BW_PSUM_DEF    = 22;
   localparam int LEN_BW_DEF     = 8;
   localparam int ACC_BW_DEF     = BW_PSUM_DEF + LEN_BW_DEF;
   localparam int FIFO_DEPTH_DEF = 2;

   // Clamp limits at the default accumulator width; the top derives its own for overrides.
   localparam logic [ACC_BW_DEF-1:0] SAT_MAX = {1'b0, {(ACC_BW_DEF-1){1'b1}}};
   localparam logic [ACC_BW_DEF-1:0] SAT_MIN = {1'b1, {(ACC_BW_DEF-1){1'b0}}};

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

endpackage

// File: rtl/psum_accum_if.sv
// Valid/ready stream bundle used for the psum input and the result output.
// Latency: n/a (wiring only).
// Backpressure: ready driven by the slave side.
interface psum_accum_if #(
   parameter int W = 22
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/psum_accum_fifo.sv
// Small synchronous result FIFO with count, full/empty and a held head value.
// Latency: push at edge t is visible at the head from t+1.
// Backpressure: push ignored when full, pop ignored when empty.
module psum_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] last_q;
   logic             push_en;
   logic             pop_en;

   assign empty    = (cnt == '0);
   assign full     = (cnt == CW'(DEPTH));
   assign push_en  = push && !full;
   assign pop_en   = pop && !empty;
   assign count    = cnt;
   // When drained the output keeps showing the most recently popped entry.
   assign head_dat = empty ? last_q : mem[rd_ptr];

   // Storage write on push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_en) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_en, pop_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Capture the entry leaving the FIFO so the head holds it once empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= '0;
      end else if (pop_en) begin
         last_q <= mem[rd_ptr];
      end
   end

endmodule

// File: rtl/psum_accum.sv
// Accumulates cfg_len signed psums into one saturating result and queues it for the SRAM writer.
// Latency: result pushed on the edge accepting the last psum, out valid from the next cycle.
// Backpressure: in ready only while the FIFO has room; psums offered when not ready are dropped and flagged.
module psum_accum
   import psum_accum_pkg::*;
#(
   parameter int BW_PSUM    = BW_PSUM_DEF,
   parameter int ACC_BW     = ACC_BW_DEF,
   parameter int LEN_BW     = LEN_BW_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   psum_accum_if.slave       in_if,
   psum_accum_if.master      out_if,
   input  logic [LEN_BW-1:0] cfg_len,
   output logic              sat_flag,
   output logic              drop_flag
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ACC_BW-1:0] MAX_V = {1'b0, {(ACC_BW-1){1'b1}}};
   localparam logic [ACC_BW-1:0] MIN_V = {1'b1, {(ACC_BW-1){1'b0}}};

   state_t            state_q;
   state_t            state_d;
   logic [ACC_BW-1:0] acc_q;
   logic [ACC_BW-1:0] acc_d;
   logic [LEN_BW-1:0] cnt_q;
   logic [LEN_BW-1:0] cnt_d;
   logic [LEN_BW-1:0] len_q;
   logic [LEN_BW-1:0] len_d;

   logic              accept;
   logic              drop;
   logic [LEN_BW-1:0] eff_len;
   logic [ACC_BW-1:0] psum_ext;
   logic [ACC_BW:0]   sum_wide;
   logic              ovf;
   logic [ACC_BW-1:0] sat_val;
   logic              sat_hit;

   logic              push_req;
   logic [ACC_BW-1:0] push_dat;
   logic              push_en;
   logic              pop_en;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [ACC_BW-1:0] fifo_head;

   // Ready comes from the registered count only; reset holds it low.
   assign in_if.ready = reset_n && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign accept      = in_if.valid && in_if.ready;
   assign drop        = in_if.valid && !in_if.ready;

   assign eff_len  = (cfg_len == '0) ? LEN_BW'(1) : cfg_len;
   assign psum_ext = {{(ACC_BW-BW_PSUM){in_if.data[BW_PSUM-1]}}, in_if.data};

   // One guard bit catches overflow; clamp toward the sign of the true sum.
   assign sum_wide = {acc_q[ACC_BW-1], acc_q} + {psum_ext[ACC_BW-1], psum_ext};
   assign ovf      = sum_wide[ACC_BW] ^ sum_wide[ACC_BW-1];
   assign sat_val  = ovf ? (sum_wide[ACC_BW] ? MIN_V : MAX_V) : sum_wide[ACC_BW-1:0];

   // Group state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // Per accepted psum: start, extend or close a group; idle cycles hold everything.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      push_req = 1'b0;
      push_dat = '0;
      sat_hit  = 1'b0;
      if (accept) begin
         case (state_q)
            IDLE: begin
               if (eff_len == LEN_BW'(1)) begin
                  push_req = 1'b1;
                  push_dat = psum_ext;
               end else begin
                  acc_d   = psum_ext;
                  cnt_d   = LEN_BW'(1);
                  len_d   = eff_len;
                  state_d = ACC;
               end
            end
            ACC: begin
               sat_hit = ovf;
               if (cnt_q == len_q - 1'b1) begin
                  push_req = 1'b1;
                  push_dat = sat_val;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  acc_d = sat_val;
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Sticky status flags, cleared only by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sat_flag  <= 1'b0;
         drop_flag <= 1'b0;
      end else begin
         sat_flag  <= sat_flag | sat_hit;
         drop_flag <= drop_flag | drop;
      end
   end

   assign push_en      = push_req && !fifo_full;
   assign pop_en       = out_if.valid && out_if.ready;
   assign out_if.valid = !fifo_empty;
   assign out_if.data  = fifo_head;

   psum_fifo #(
      .WIDTH (ACC_BW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push_en),
      .push_dat (push_dat),
      .pop      (pop_en),
      .head_dat (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

endmodule
